// File: rtl/gpu_rect_fill_pkg.sv
// Shared types and constants for the rectangle fill engine.
// Holds the FSM state encoding, the draw-mode encoding and the default screen geometry.
package gpu_rect_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_FILL    = 1'b0,
        MODE_OUTLINE = 1'b1
    } mode_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 400;
    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_COORD_W  = 10;

    function automatic logic [31:0] clamp_max(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/gpu_rect_scan.sv
// Pixel walker: steps x/y across the rectangle in row-major order and forms the SRAM address.
// The row base is multiplied once on load and then advanced by SCREEN_W per row.
module gpu_rect_scan
    import gpu_rect_fill_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int COORD_W  = DEF_COORD_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  mode_t              mode_i,
    input  logic [COORD_W-1:0] xmin_i,
    input  logic [COORD_W-1:0] xmax_i,
    input  logic [COORD_W-1:0] ymin_i,
    input  logic [COORD_W-1:0] ymax_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               last_o
);

    logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q, x_q, y_q;
    logic [COORD_W-1:0] xmin_d, xmax_d, ymin_d, ymax_d, x_d, y_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic               outline_q, outline_d;
    logic               interior_row;

    assign last_o       = (x_q == xmax_q) && (y_q == ymax_q);
    assign addr_o       = row_base_q + ADDR_W'(x_q);
    assign interior_row = (y_q != ymin_q) && (y_q != ymax_q);

    always_comb begin
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymin_d     = ymin_q;
        ymax_d     = ymax_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        outline_d  = outline_q;
        if (load_i) begin
            xmin_d     = xmin_i;
            xmax_d     = xmax_i;
            ymin_d     = ymin_i;
            ymax_d     = ymax_i;
            x_d        = xmin_i;
            y_d        = ymin_i;
            row_base_d = ADDR_W'(32'(ymin_i) * 32'(SCREEN_W));
            outline_d  = (mode_i == MODE_OUTLINE);
        end else if (step_i && !last_o) begin
            if (x_q == xmax_q) begin
                x_d        = xmin_q;
                y_d        = y_q + COORD_W'(1);
                row_base_d = row_base_q + ADDR_W'(SCREEN_W);
            end else if (outline_q && interior_row && (x_q == xmin_q)) begin
                // Outline interior rows skip straight from the left edge to the right edge.
                x_d = xmax_q;
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            outline_q  <= 1'b0;
        end else begin
            xmin_q     <= xmin_d;
            xmax_q     <= xmax_d;
            ymin_q     <= ymin_d;
            ymax_q     <= ymax_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            outline_q  <= outline_d;
        end
    end

endmodule

// File: rtl/gpu_rect_fill.sv
// Rectangle fill/outline engine writing pixels into SRAM during video blanking.
// Holds the command handshake, the IDLE/SETUP/DRAW/DONE sequencer and the registered SRAM port.
module gpu_rect_fill
    import gpu_rect_fill_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int COORD_W  = DEF_COORD_W
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic               I_VIDEO_ON,
    input  logic               I_CMD_VALID,
    output logic               O_CMD_READY,
    input  logic [COORD_W-1:0] I_CMD_X0,
    input  logic [COORD_W-1:0] I_CMD_Y0,
    input  logic [COORD_W-1:0] I_CMD_X1,
    input  logic [COORD_W-1:0] I_CMD_Y1,
    input  logic               I_CMD_MODE,
    input  logic [DATA_W-1:0]  I_CMD_COLOR,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [DATA_W-1:0]  O_GPU_DATA,
    output logic               O_GPU_WRITE,
    output logic               O_GPU_READ,
    output logic               O_BUSY,
    output logic               O_DONE
);

    state_t             state_q;
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    mode_t              mode_q;
    logic [DATA_W-1:0]  color_q;
    logic               ready_q, busy_q, done_q, fin_q;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;

    logic [COORD_W-1:0] x_lo, x_hi, y_lo, y_hi;
    logic [COORD_W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
    logic               issue;
    logic [ADDR_W-1:0]  scan_addr;
    logic               scan_last;

    // Corner ordering and clamping, consumed by the scanner while in SETUP.
    always_comb begin
        x_lo   = (x0_q <= x1_q) ? x0_q : x1_q;
        x_hi   = (x0_q <= x1_q) ? x1_q : x0_q;
        y_lo   = (y0_q <= y1_q) ? y0_q : y1_q;
        y_hi   = (y0_q <= y1_q) ? y1_q : y0_q;
        xmin_c = COORD_W'(clamp_max(32'(x_lo), 32'(SCREEN_W - 1)));
        xmax_c = COORD_W'(clamp_max(32'(x_hi), 32'(SCREEN_W - 1)));
        ymin_c = COORD_W'(clamp_max(32'(y_lo), 32'(SCREEN_H - 1)));
        ymax_c = COORD_W'(clamp_max(32'(y_hi), 32'(SCREEN_H - 1)));
    end

    // fin_q marks that the last pixel has been issued; DRAW lingers one cycle so it lands.
    assign issue = (state_q == ST_DRAW) && !fin_q && !I_VIDEO_ON;

    gpu_rect_scan #(
        .SCREEN_W (SCREEN_W),
        .ADDR_W   (ADDR_W),
        .COORD_W  (COORD_W)
    ) u_scan (
        .clk_i  (I_CLK),
        .rst_i  (I_RST),
        .load_i (state_q == ST_SETUP),
        .step_i (issue),
        .mode_i (mode_q),
        .xmin_i (xmin_c),
        .xmax_i (xmax_c),
        .ymin_i (ymin_c),
        .ymax_i (ymax_c),
        .addr_o (scan_addr),
        .last_o (scan_last)
    );

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            mode_q  <= MODE_FILL;
            color_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            write_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (I_CMD_VALID && ready_q) begin
                        x0_q    <= I_CMD_X0;
                        y0_q    <= I_CMD_Y0;
                        x1_q    <= I_CMD_X1;
                        y1_q    <= I_CMD_Y1;
                        mode_q  <= mode_t'(I_CMD_MODE);
                        color_q <= I_CMD_COLOR;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    fin_q   <= 1'b0;
                    state_q <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (fin_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (issue) begin
                        write_q <= 1'b1;
                        addr_q  <= scan_addr;
                        data_q  <= color_q;
                        fin_q   <= scan_last;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign O_CMD_READY = ready_q;
    assign O_BUSY      = busy_q;
    assign O_DONE      = done_q;
    assign O_GPU_WRITE = write_q;
    assign O_GPU_ADDR  = addr_q;
    assign O_GPU_DATA  = data_q;
    assign O_GPU_READ  = 1'b0;

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Self-checking bench for gpu_rect_fill: table of directed rectangles plus
// hand-written sequences for video stalls, mid-draw reset and back-to-back commands.
module tb_gpu_rect_fill;

    localparam int SW = 640;
    localparam int SH = 400;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          video_on = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_mode = 1'b0;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [DW-1:0] color = '0;
    logic          cmd_ready, gpu_write, gpu_read, busy, done;
    logic [AW-1:0] gpu_addr;
    logic [DW-1:0] gpu_data;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int wa[$];
    int wd[$];
    int wc[$];
    int dc[$];
    int ea[$];

    typedef struct {
        int x0, y0, x1, y1;
        int mode;
        int color;
        int n;
        int first;
        int last;
    } vec_t;

    vec_t vecs[7];

    gpu_rect_fill dut (
        .I_CLK       (clk),
        .I_RST       (rst),
        .I_VIDEO_ON  (video_on),
        .I_CMD_VALID (cmd_valid),
        .O_CMD_READY (cmd_ready),
        .I_CMD_X0    (x0),
        .I_CMD_Y0    (y0),
        .I_CMD_X1    (x1),
        .I_CMD_Y1    (y1),
        .I_CMD_MODE  (cmd_mode),
        .I_CMD_COLOR (color),
        .O_GPU_ADDR  (gpu_addr),
        .O_GPU_DATA  (gpu_data),
        .O_GPU_WRITE (gpu_write),
        .O_GPU_READ  (gpu_read),
        .O_BUSY      (busy),
        .O_DONE      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (gpu_write) begin
            wa.push_back(int'(gpu_addr));
            wd.push_back(int'(gpu_data));
            wc.push_back(cyc);
        end
        if (done) dc.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference pixel list, built by brute-force scan of the bounding box.
    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1, input int m);
        int xl, xh, yl, yh;
        ea.delete();
        xl = (ax0 < ax1) ? ax0 : ax1;
        xh = (ax0 < ax1) ? ax1 : ax0;
        yl = (ay0 < ay1) ? ay0 : ay1;
        yh = (ay0 < ay1) ? ay1 : ay0;
        if (xl > SW - 1) xl = SW - 1;
        if (xh > SW - 1) xh = SW - 1;
        if (yl > SH - 1) yl = SH - 1;
        if (yh > SH - 1) yh = SH - 1;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                if (m == 0 || y == yl || y == yh || x == xl || x == xh)
                    ea.push_back(y * SW + x);
    endtask

    task automatic send(input int ax0, input int ay0, input int ax1, input int ay1,
                        input int m, input int col, output int t_acc);
        wa.delete(); wd.delete(); wc.delete(); dc.delete();
        @(posedge clk); #1;
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        cmd_mode = m[0];
        color = DW'(col);
        cmd_valid = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                t_acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("accepted", int'(t_acc >= 0), 1);
        @(negedge clk);
        check("busy_in_setup", int'(busy), 1);
        check("ready_low_in_setup", int'(cmd_ready), 0);
    endtask

    task automatic wait_done(input int need, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (dc.size() >= need) break;
        end
        check("done_seen", int'(dc.size() >= need), 1);
    endtask

    task automatic wait_writes(input int need);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (wa.size() >= need) break;
        end
    endtask

    function automatic int seq_mismatches();
        int bad = 0;
        for (int i = 0; i < ea.size(); i++)
            if (i >= wa.size() || wa[i] != ea[i]) bad++;
        return bad;
    endfunction

    initial begin
        int t, t2, bad, gaps, maxgap;

        vecs[0] = '{2, 1, 4, 2, 0, 'h0F00, 6, 642, 1284};
        vecs[1] = '{0, 0, 3, 3, 1, 'h00F0, 12, 0, 1923};
        vecs[2] = '{700, 450, 638, 398, 0, 'h1234, 4, 255358, 255999};
        vecs[3] = '{5, 5, 5, 5, 1, 'h0001, 1, 3205, 3205};
        vecs[4] = '{10, 2, 14, 2, 1, 'h0002, 5, 1290, 1294};
        vecs[5] = '{7, 0, 7, 3, 1, 'h0003, 4, 7, 1927};
        vecs[6] = '{3, 1, 1, 4, 1, 'hBEEF, 10, 641, 2563};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_write", int'(gpu_write), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(cmd_ready), 1);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_done", int'(done), 0);
        check("post_rst_addr", int'(gpu_addr), 0);
        check("post_rst_data", int'(gpu_data), 0);
        check("post_rst_read", int'(gpu_read), 0);

        // Directed table
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].mode, vecs[v].color, t);
            wait_done(1, 300);
            repeat (3) @(negedge clk);
            #2;
            model(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].mode);
            check($sformatf("v%0d_count", v), wa.size(), vecs[v].n);
            check($sformatf("v%0d_first_addr", v), (wa.size() > 0) ? wa[0] : -1, vecs[v].first);
            check($sformatf("v%0d_last_addr", v), (wa.size() > 0) ? wa[wa.size()-1] : -1, vecs[v].last);
            check($sformatf("v%0d_sequence", v), seq_mismatches(), 0);
            bad = 0;
            foreach (wd[i]) if (wd[i] != vecs[v].color) bad++;
            check($sformatf("v%0d_data", v), bad, 0);
            check($sformatf("v%0d_first_latency", v), (wc.size() > 0) ? wc[0] - t : -1, 3);
            check($sformatf("v%0d_done_latency", v), (dc.size() > 0) ? dc[0] - t : -1, vecs[v].n + 3);
            check($sformatf("v%0d_single_done", v), dc.size(), 1);
            if (vecs[v].mode == 1 && vecs[v].x0 == 0 && vecs[v].x1 == 3) begin
                bad = 0;
                foreach (wa[i]) if (wa[i] == 641 || wa[i] == 642) bad++;
                check("outline_no_interior", bad, 0);
            end
        end

        // Video stall for 5 cycles mid-fill
        send(0, 5, 19, 5, 0, 'hABCD, t);
        wait_writes(3);
        #1 video_on = 1'b1;
        repeat (5) @(posedge clk);
        #1 video_on = 1'b0;
        wait_done(1, 300);
        model(0, 5, 19, 5, 0);
        check("stall_count", wa.size(), 20);
        check("stall_sequence", seq_mismatches(), 0);
        gaps = 0; maxgap = 0;
        for (int i = 1; i < wc.size(); i++) begin
            if (wc[i] - wc[i-1] != 1) gaps++;
            if (wc[i] - wc[i-1] > maxgap) maxgap = wc[i] - wc[i-1];
        end
        check("stall_gap_count", gaps, 1);
        check("stall_gap_len", maxgap, 6);
        check("stall_done_latency", (dc.size() > 0) ? dc[0] - t : -1, 28);

        // Asynchronous reset after 3 writes of a 10x10 fill
        send(0, 0, 9, 9, 0, 'h5555, t);
        wait_writes(3);
        #1 rst = 1'b1;
        #1;
        check("arst_write", int'(gpu_write), 0);
        check("arst_addr", int'(gpu_addr), 0);
        check("arst_data", int'(gpu_data), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ready", int'(cmd_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        #2;
        check("arst_write_count", wa.size(), 3);
        check("arst_no_done", dc.size(), 0);
        send(2, 1, 4, 2, 0, 'h0F00, t);
        wait_done(1, 300);
        model(2, 1, 4, 2, 0);
        check("arst_next_count", wa.size(), 6);
        check("arst_next_sequence", seq_mismatches(), 0);
        check("arst_next_done", (dc.size() > 0) ? dc[0] - t : -1, 9);

        // Valid held while busy: second command taken the cycle after O_DONE
        wa.delete(); wd.delete(); wc.delete(); dc.delete();
        @(posedge clk); #1;
        x0 = CW'(2); y0 = CW'(1); x1 = CW'(4); y1 = CW'(2); cmd_mode = 1'b0; color = 16'h0F00;
        cmd_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin t = cyc; break; end
        end
        @(posedge clk); #1;
        x0 = CW'(0); y0 = CW'(0); x1 = CW'(3); y1 = CW'(3); cmd_mode = 1'b1; color = 16'h00F0;
        t2 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin t2 = cyc; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("b2b_first_accept", int'(t >= 0), 1);
        check("b2b_second_after_done", t2, (dc.size() > 0) ? dc[0] + 1 : -1);
        check("b2b_accept_spacing", t2 - t, 10);
        wait_done(2, 300);
        check("b2b_total_writes", wa.size(), 18);
        check("b2b_second_first_addr", (wa.size() > 6) ? wa[6] : -1, 0);
        check("b2b_second_last_addr", (wa.size() > 17) ? wa[17] : -1, 1923);
        check("b2b_second_done", (dc.size() > 1) ? dc[1] - t2 : -1, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpu_rect_fill.md
GPU_RECT_FILL -- requirements
Module: gpu_rect_fill

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, frame width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 400, frame height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-004 SHALL have parameter DATA_W, default 16, pixel/SRAM data width.
REQ-005 SHALL have parameter COORD_W, default 10, coordinate width.
REQ-006 I_CLK  input  1  sole clock; all logic on rising edge.
REQ-007 I_RST  input  1  reset, asynchronous, active-high.
REQ-008 I_VIDEO_ON  input  1  high = active display; SRAM writes forbidden.
REQ-009 I_CMD_VALID  input  1  command present.
REQ-010 O_CMD_READY  output  1  engine can accept a command.
REQ-011 I_CMD_X0, I_CMD_Y0, I_CMD_X1, I_CMD_Y1  input  COORD_W each  rectangle corners, inclusive.
REQ-012 I_CMD_MODE  input  1  0 = solid fill, 1 = outline only.
REQ-013 I_CMD_COLOR  input  DATA_W  pixel value.
REQ-014 O_GPU_ADDR  output  ADDR_W  SRAM address.
REQ-015 O_GPU_DATA  output  DATA_W  SRAM write data.
REQ-016 O_GPU_WRITE  output  1  SRAM write strobe, one pixel per high cycle.
REQ-017 O_GPU_READ  output  1  SRAM read strobe; constant 0 in this generation.
REQ-018 O_BUSY  output  1  command in progress.
REQ-019 O_DONE  output  1  one-cycle pulse when a command finishes.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, DRAW, DONE.
REQ-021 O_CMD_READY SHALL be high only in IDLE; a command is accepted on a cycle with I_CMD_VALID and O_CMD_READY both high, and all command fields are registered that cycle.
REQ-022 IDLE->SETUP on acceptance; SETUP->DRAW after exactly one cycle; DRAW->DONE after the last pixel is written; DONE->IDLE after one cycle with O_DONE high.
REQ-023 SETUP SHALL order corners (swap if X0>X1 or Y0>Y1) and clamp X to SCREEN_W-1 and Y to SCREEN_H-1.
REQ-024 SETUP SHALL compute row base = ymin*SCREEN_W; in DRAW the row base SHALL advance by adding SCREEN_W per row (no per-pixel multiply).
REQ-025 Pixel address SHALL be row base + x, truncated to ADDR_W.
REQ-026 In DRAW, a pixel SHALL be issued only on a cycle where I_VIDEO_ON is sampled low; O_GPU_ADDR/O_GPU_DATA/O_GPU_WRITE are registered, so the write appears one cycle after the issuing cycle.
REQ-027 While I_VIDEO_ON is high, O_GPU_WRITE SHALL be 0 the following cycle, and x/y/row base SHALL hold; drawing resumes at the same pixel.
REQ-028 Scan order SHALL be row-major, x ascending within row, rows ascending.
REQ-029 Solid mode SHALL write every pixel in [xmin..xmax]x[ymin..ymax] exactly once.
REQ-030 Outline mode SHALL write all pixels of rows ymin and ymax and only xmin and xmax on other rows, jumping x from xmin directly to xmax (interior row = 2 issue cycles, 1 if xmin==xmax).
REQ-031 Degenerate rectangles (single pixel, single row, single column) SHALL write each covered pixel exactly once in both modes.
REQ-032 O_BUSY SHALL be high in SETUP, DRAW and DONE.
REQ-033 Minimum latency: accept at cycle T, first write visible at T+3 with video off; an N-pixel command with no video stalls gives O_DONE at T+N+3.

Reset
REQ-034 Asserting I_RST SHALL immediately force IDLE, O_GPU_WRITE=0, O_GPU_READ=0, O_GPU_ADDR=0, O_GPU_DATA=0, O_BUSY=0, O_DONE=0, O_CMD_READY=1 after reset, internal counters 0.
REQ-035 Reset mid-DRAW SHALL abandon the command without a further write or O_DONE pulse.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the mode encoding (FILL=0, OUTLINE=1) and default screen constants.
REQ-037 One sub-module, gpu_rect_scan, SHALL hold the x/y/row-base stepping logic; the top holds FSM, handshake and output registers.

Verification
REQ-038 Solid (2,1)-(4,2), color 16'h0F00, video off -> 6 writes to addrs 642,643,644,1282,1283,1284, then O_DONE at T+9.
REQ-039 Outline (0,0)-(3,3) -> 12 writes; row 1 writes only addrs 640 and 643; no interior address written.
REQ-040 Swapped/oversize (700,450)-(638,398) -> clamped to (638..639,398..399): writes 255358,255359,255998,255999.
REQ-041 I_VIDEO_ON high for 5 cycles mid-fill -> O_GPU_WRITE low for 5 cycles, no pixel skipped or duplicated.
REQ-042 I_RST pulsed after 3 writes of a 10x10 fill -> outputs zero asynchronously, no O_DONE, next command accepted normally.
REQ-043 I_CMD_VALID held while O_BUSY -> second command accepted exactly in cycle after O_DONE.
